ramfile_wr: RTL
===============

Name: ramfile_wr

Overview:
- Write-side (consumer) end of the DBUS: captures 36-bit DBUS results into the ramfile and serves ramfile reads back to the DBUS multiplexer's RAM input.
- Owns the single port of an external synchronous ramfile RAM (1-cycle read latency).
- Posts writes through a 2-entry write buffer and forwards buffered data to reads so the CPU never sees stale ramfile data.

Parameters:
- ADDR_WIDTH, 10, ramfile address width (1024 words)
- DATA_WIDTH, 36, word width, bit 0 = MSB, matching the [0:35] datapath convention

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- wr_req  in  1  write request; DBUS word to be stored
- wr_addr  in  ADDR_WIDTH  write address
- dbus  in  [0:DATA_WIDTH-1]  write data (DBUS)
- wr_rdy  out  1  write accepted this cycle when wr_req & wr_rdy
- rd_req  in  1  read request
- rd_addr  in  ADDR_WIDTH  read address
- rd_rdy  out  1  read accepted this cycle when rd_req & rd_rdy
- rd_data  out  [0:DATA_WIDTH-1]  read data to the DBUS RAM input; held until next read completes
- rd_valid  out  1  one-cycle pulse, rd_data valid
- ram_addr  out  ADDR_WIDTH  RAM address (combinational)
- ram_we  out  1  RAM write enable (combinational)
- ram_wdata  out  [0:DATA_WIDTH-1]  RAM write data (combinational)
- ram_rdata  in  [0:DATA_WIDTH-1]  RAM read data, valid the cycle after the read address is presented

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - Buffer count = 0; rd_valid = 0; rd_data = 0; internal read-pending flag = 0.
  - Any in-flight read or buffered write is discarded; no rd_valid follows.
- Write buffer: 2-entry FIFO of {addr, data}; count 0..2.
  - wr_rdy = (count < 2), combinational from registered state.
  - An accepted write is enqueued at the edge.
- Port arbitration, each cycle, evaluated on state before the edge:
  - P1: count == 2 → drain head; rd_rdy = 0.
  - P2: rd_req & count < 2 → read owns the port; rd_rdy = 1; no drain.
  - P3: count > 0 and no read → drain head.
  - Drain: ram_we = 1, ram_addr/ram_wdata = head entry; entry dequeued at the edge.
  - Otherwise ram_we = 0 and ram_addr = rd_addr.
  - Enqueue and dequeue in the same cycle: count is unchanged, FIFO order is preserved.
- Read and forwarding:
  - An accepted read compares rd_addr against valid buffer entries, newest first.
  - Hit: latch that entry's data; on the next edge rd_data = latched data (not ram_rdata).
  - Miss: ram_addr = rd_addr; on the next edge rd_data = ram_rdata.
  - Latency is always exactly 1: rd_valid = 1 in the cycle after acceptance. Back-to-back reads give one rd_valid per cycle.
  - A write accepted in the same cycle as a read is not visible to that read. It is visible to any read accepted in a later cycle.
  - Two buffered entries to the same address: the newest wins.
- Ordering: RAM writes occur in acceptance order. The RAM never sees a write to a line out of order.
- No combinational path from wr_req or dbus to wr_rdy or rd_rdy.

Test Plan:
- Reset: hold rst_n=0 for 2 clocks with wr_req=1, rd_req=1 → count=0, rd_valid=0, rd_data=0, ram_we=0, wr_rdy=1.
- Posted write then drain: write addr 0o17 data 0o123456_701234, no reads → ram_we=1 next cycle with that addr/data; count returns to 0.
- Forwarding: three writes while rd_req=1 every cycle. The third write is blocked: wr_rdy=0 with count=2, P1 drains the head. Then read 0o17 after writing 0o17←A then 0o17←B → rd_valid next cycle, rd_data=B, RAM not read.
- Same-cycle hazard: write 0o20←C and read 0o20 in the same cycle, RAM[0o20]=D → rd_data=D. A read in the next cycle returns C.
- Full buffer: count=2, rd_req=1 → rd_rdy=0 and ram_we=1 (head drained). On the following cycle rd_rdy=1 and the read completes with 1-cycle latency.
- Reset mid-operation: count=2 and a read pending, assert rst_n=0 → no rd_valid pulse, ram_we=0 after the edge, buffered writes never reach the RAM.

Source files
------------

// File: rtl/ramfile_wr.sv
// ramfile_wr: consumer end of the DBUS. Accepted writes are posted into a
// 2-entry FIFO and drained into the single-port ramfile RAM whenever the
// port is free. Reads take exactly one cycle. A read is served from the
// newest matching buffered entry when there is one, and from the RAM
// otherwise, so a read never returns stale ramfile data.
module ramfile_wr #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 36
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [0:DATA_WIDTH-1] dbus,
  output logic                  wr_rdy,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_rdy,
  output logic [0:DATA_WIDTH-1] rd_data,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [0:DATA_WIDTH-1] ram_wdata,
  input  logic [0:DATA_WIDTH-1] ram_rdata
);

  // Write buffer storage (two slots) and its head pointer / occupancy.
  logic [ADDR_WIDTH-1:0] buf_addr_q [2];
  logic [ADDR_WIDTH-1:0] buf_addr_d [2];
  logic [0:DATA_WIDTH-1] buf_data_q [2];
  logic [0:DATA_WIDTH-1] buf_data_d [2];
  logic                  head_q, head_d;
  logic [1:0]            count_q, count_d;

  // Read pipeline: pending flag, forward-hit flag, forwarded word, held result.
  logic                  pend_q, pend_d;
  logic                  hit_q, hit_d;
  logic [0:DATA_WIDTH-1] fwd_q, fwd_d;
  logic [0:DATA_WIDTH-1] rd_data_q, rd_data_d;

  // Intermediate decode.
  logic                  full;
  logic                  drain_go;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  tail;
  logic                  newest;
  logic                  fwd_hit;
  logic [0:DATA_WIDTH-1] fwd_word;

  // Port arbitration, forwarding lookup and all next-state values.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    buf_addr_d = buf_addr_q;
    buf_data_d = buf_data_q;
    head_d     = head_q;
    count_d    = count_q;
    fwd_d      = fwd_q;
    fwd_hit    = 1'b0;
    fwd_word   = fwd_q;

    full   = (count_q == 2'd2);
    wr_rdy = ~full;
    rd_rdy = ~full;
    wr_acc = wr_req & ~full;
    rd_acc = rd_req & ~full;

    // A full buffer always drains; otherwise a pending read keeps the port.
    // Drains are suppressed while reset is asserted so that discarded
    // entries never reach the RAM.
    drain_go = rst_n & (full | ((count_q != 2'd0) & ~rd_req));

    // Slot that the next write lands in, and slot holding the newest entry.
    tail   = head_q ^ count_q[0];
    newest = head_q ^ full;

    // Newest matching entry wins. The write accepted this cycle is not yet
    // in the buffer, so it is invisible to this read.
    if ((count_q != 2'd0) && (buf_addr_q[newest] == rd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_word = buf_data_q[newest];
    end else if (full && (buf_addr_q[head_q] == rd_addr)) begin
      fwd_hit  = 1'b1;
      fwd_word = buf_data_q[head_q];
    end

    if (wr_acc) begin
      buf_addr_d[tail] = wr_addr;
      buf_data_d[tail] = dbus;
    end
    if (drain_go) head_d = ~head_q;

    case ({wr_acc, drain_go})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    pend_d = rd_acc;
    hit_d  = rd_acc & fwd_hit;
    if (rd_acc && fwd_hit) fwd_d = fwd_word;

    // Completed read: forwarded word or RAM word; otherwise hold last result.
    if (pend_q && rst_n) rd_data_d = hit_q ? fwd_q : ram_rdata;
    else                 rd_data_d = rd_data_q;

    rd_valid  = pend_q & rst_n;
    rd_data   = rd_data_d;
    ram_we    = drain_go;
    ram_addr  = drain_go ? buf_addr_q[head_q] : rd_addr;
    ram_wdata = buf_data_q[head_q];
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      head_q    <= 1'b0;
      count_q   <= 2'd0;
      pend_q    <= 1'b0;
      hit_q     <= 1'b0;
      rd_data_q <= '0;
    end else begin
      head_q    <= head_d;
      count_q   <= count_d;
      pend_q    <= pend_d;
      hit_q     <= hit_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Buffer payload and forwarded word.
  always_ff @(posedge clk) begin
    // NOTE: payload storage is deliberately not reset; count_q and hit_q
    // qualify every use, so stale contents are never observed.
    buf_addr_q <= buf_addr_d;
    buf_data_q <= buf_data_d;
    fwd_q      <= fwd_d;
  end

endmodule
